// File: rtl/decode_stage.sv
// Decode stage: splits the fetched instruction into fields, reads the integer register file
// (with same-cycle writeback bypass) and registers everything into the D/E pipeline register.
module decode_stage #(
  parameter int NREG   = 32,
  parameter int RA_IDX = 31
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     wb_we,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [31:0]              wb_data,
  output logic                     de_valid,
  output logic [31:0]              de_pc,
  output logic [1:0]               de_op_type,
  output logic [5:0]               de_instr,
  output logic [31:0]              de_s,
  output logic [31:0]              de_rs,
  output logic [31:0]              de_t,
  output logic [31:0]              de_rt,
  output logic [31:0]              de_rd,
  output logic [31:0]              de_imm,
  output logic                     de_branch,
  output logic                     de_jump,
  output logic                     de_is_jr
);

  localparam int IW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_FPU   = 6'h11;
  localparam logic [5:0] OP_IN    = 6'h1A;
  localparam logic [5:0] OP_OUT   = 6'h1B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW_S  = 6'h31;
  localparam logic [5:0] OP_SW_S  = 6'h39;
  localparam logic [5:0] FUNC_JR  = 6'h08;

  // ---------------------------------------------------------------- register file
  logic [31:0] rf [NREG];

  // Each register is its own flop bank so the whole file clears on reset.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_reg
        logic [31:0] r_reg;
        always_ff @(posedge clk) begin
          if (!rstn)
            r_reg <= '0;
          else if (wb_we && wb_addr == IW'(gi))
            r_reg <= wb_data;
        end
        assign rf[gi] = r_reg;
      end
    end
  endgenerate

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [IW-1:0] rs_idx;
  logic [IW-1:0] rt_idx;
  logic [IW-1:0] rd_idx;
  logic [31:0]   rs_val;
  logic [31:0]   rt_val;

  assign op     = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign rs_idx = in_instr[25:21];
  assign rt_idx = in_instr[20:16];
  assign rd_idx = in_instr[15:11];

  // Bypass lets a writeback in this cycle be seen by the instruction decoding now.
  always_comb begin
    rs_val = rf[rs_idx];
    rt_val = rf[rt_idx];
    if (wb_we && wb_addr != '0 && wb_addr == rs_idx) rs_val = wb_data;
    if (wb_we && wb_addr != '0 && wb_addr == rt_idx) rt_val = wb_data;
  end

  // ---------------------------------------------------------------- decode
  logic [1:0]    dec_op_type;
  logic [5:0]    dec_instr;
  logic [IW-1:0] dec_dest;
  logic [31:0]   dec_imm;
  logic [31:0]   dec_s;
  logic          dec_branch;
  logic          dec_jump;
  logic          dec_is_jr;

  always_comb begin
    dec_op_type = 2'b00;
    dec_instr   = op;
    dec_dest    = '0;
    dec_imm     = {{16{in_instr[15]}}, in_instr[15:0]};
    dec_s       = rs_val;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_is_jr   = 1'b0;
    if (op == OP_RTYPE) begin
      dec_op_type = 2'b01;
      dec_instr   = funct;
      if (funct == FUNC_JR)
        dec_is_jr = 1'b1;
      else
        dec_dest = rd_idx;
    end else if (op == OP_FPU) begin
      dec_op_type = 2'b10;
      dec_instr   = funct;
      dec_dest    = rd_idx;
    end else begin
      case (op)
        OP_ADDI, OP_SLTI, OP_LUI, OP_LW, OP_LW_S, OP_IN: dec_dest = rt_idx;
        OP_ANDI, OP_ORI, OP_XORI: begin
          dec_dest = rt_idx;
          dec_imm  = {16'b0, in_instr[15:0]};
        end
        OP_JAL: begin
          dec_dest = IW'(RA_IDX);
          dec_jump = 1'b1;
          dec_imm  = {6'b0, in_instr[25:0]};
          dec_s    = in_pc + 32'd4;
        end
        OP_J: begin
          dec_jump = 1'b1;
          dec_imm  = {6'b0, in_instr[25:0]};
        end
        OP_BEQ, OP_BNE: dec_branch = 1'b1;
        // Stores, OUT and undefined opcodes have no destination.
        OP_SW, OP_SW_S, OP_OUT: dec_dest = '0;
        default: dec_dest = '0;
      endcase
    end
  end

  assign in_ready = ~stall | flush;

  // ---------------------------------------------------------------- D/E register
  // A bubble is the all-zero encoding so it can never write, branch or touch the UART.
  always_ff @(posedge clk) begin
    if (!rstn || flush || (!stall && !in_valid)) begin
      de_valid   <= 1'b0;
      de_pc      <= '0;
      de_op_type <= '0;
      de_instr   <= '0;
      de_s       <= '0;
      de_rs      <= '0;
      de_t       <= '0;
      de_rt      <= '0;
      de_rd      <= '0;
      de_imm     <= '0;
      de_branch  <= 1'b0;
      de_jump    <= 1'b0;
      de_is_jr   <= 1'b0;
    end else if (!stall) begin
      de_valid   <= 1'b1;
      de_pc      <= in_pc;
      de_op_type <= dec_op_type;
      de_instr   <= dec_instr;
      de_s       <= dec_s;
      de_rs      <= 32'(rs_idx);
      de_t       <= rt_val;
      de_rt      <= 32'(rt_idx);
      de_rd      <= 32'(dec_dest);
      de_imm     <= dec_imm;
      de_branch  <= dec_branch;
      de_jump    <= dec_jump;
      de_is_jr   <= dec_is_jr;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected D/E records, a monitor pops them on capture.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [1:0]  de_op_type;
  logic [5:0]  de_instr;
  logic [31:0] de_s, de_rs, de_t, de_rt, de_rd, de_imm;
  logic        de_branch, de_jump, de_is_jr;

  always #5 clk = ~clk;

  decode_stage #(.NREG(32), .RA_IDX(31)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .de_valid(de_valid), .de_pc(de_pc), .de_op_type(de_op_type),
    .de_instr(de_instr), .de_s(de_s), .de_rs(de_rs), .de_t(de_t), .de_rt(de_rt),
    .de_rd(de_rd), .de_imm(de_imm), .de_branch(de_branch), .de_jump(de_jump),
    .de_is_jr(de_is_jr)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  op_type;
    logic [5:0]  instr;
    logic [31:0] s;
    logic [31:0] rs;
    logic [31:0] t;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] imm;
    logic        br;
    logic        jmp;
    logic        jr;
  } de_t_s;

  de_t_s exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic de_t_s mk(input logic [31:0] pc, input logic [1:0] opt, input logic [5:0] ins,
                               input logic [31:0] s, input logic [31:0] rs, input logic [31:0] t,
                               input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] imm,
                               input logic br, input logic jmp, input logic jr);
    de_t_s e;
    e.valid = 1'b1; e.pc = pc; e.op_type = opt; e.instr = ins; e.s = s; e.rs = rs;
    e.t = t; e.rt = rt; e.rd = rd; e.imm = imm; e.br = br; e.jmp = jmp; e.jr = jr;
    return e;
  endfunction

  function automatic de_t_s sample();
    de_t_s g;
    g.valid = de_valid; g.pc = de_pc; g.op_type = de_op_type; g.instr = de_instr;
    g.s = de_s; g.rs = de_rs; g.t = de_t; g.rt = de_rt; g.rd = de_rd; g.imm = de_imm;
    g.br = de_branch; g.jmp = de_jump; g.jr = de_is_jr;
    return g;
  endfunction

  task automatic check_de(input string name, input de_t_s e);
    de_t_s g;
    g = sample();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got v=%0b pc=%h ot=%0d in=%h s=%h rs=%0d t=%h rt=%0d rd=%0d imm=%h b/j/jr=%0b%0b%0b | want v=%0b pc=%h ot=%0d in=%h s=%h rs=%0d t=%h rt=%0d rd=%0d imm=%h b/j/jr=%0b%0b%0b",
               name, g.valid, g.pc, g.op_type, g.instr, g.s, g.rs, g.t, g.rt, g.rd, g.imm, g.br, g.jmp, g.jr,
               e.valid, e.pc, e.op_type, e.instr, e.s, e.rs, e.t, e.rt, e.rd, e.imm, e.br, e.jmp, e.jr);
    end else begin
      $display("ok   %s: pc=%h ot=%0d in=%h s=%h t=%h rd=%0d imm=%h", name, g.pc, g.op_type, g.instr, g.s, g.t, g.rd, g.imm);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end else begin
      $display("ok   %s: %0b", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input de_t_s e);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: a capture happens on an edge where the stage is loading a valid instruction.
  initial begin
    logic acc;
    forever begin
      @(posedge clk);
      acc = rstn && in_valid && !stall && !flush;
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL capture: unexpected capture pc=%h, want no capture", de_pc);
        end else begin
          check_de("capture", exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_ADD3 = 32'h00A5_1820;  // ADD x3,x5,x5
  localparam logic [31:0] I_ORI  = 32'h34E8_8001;  // ORI x8,x7,0x8001
  localparam logic [31:0] I_ADDI = 32'h2001_FFFF;  // ADDI x1,x0,0xFFFF
  localparam logic [31:0] I_ADD2 = 32'h0000_1020;  // ADD x2,x0,x0
  localparam logic [31:0] I_JAL  = 32'h0C00_0040;  // JAL 0x40
  localparam logic [31:0] I_BEQ  = 32'h10A7_FFFC;  // BEQ x5,x7,-4
  localparam logic [31:0] I_JR   = 32'h00A0_0008;  // JR x5
  localparam logic [31:0] I_FPU  = 32'h44A7_4801;  // FPU funct 01 x9,x5,x7
  localparam logic [31:0] I_SW   = 32'hACA7_0010;  // SW x7,16(x5)

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    repeat (3) step();
    check_de("reset_state", '0);
    rstn = 1'b1;
    #1 check_bit("in_ready_after_reset", in_ready, 1'b1);

    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    step();
    check_de("idle_bubble", '0);
    wb_we = 1'b0;

    issue(I_ADD3, 32'h10, mk(32'h10, 2'b01, 6'h20, 32'h1234, 5, 32'h1234, 5, 3, 32'h1820, 0, 0, 0));
    step();
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE;
    issue(I_ORI, 32'h14, mk(32'h14, 2'b00, 6'h0D, 32'hCAFE, 7, 32'h0, 8, 8, 32'h0000_8001, 0, 0, 0));
    step();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    issue(I_ADDI, 32'h18, mk(32'h18, 2'b00, 6'h08, 32'h0, 0, 32'h0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0));
    step();
    wb_we = 1'b0;
    issue(I_ADD2, 32'h1C, mk(32'h1C, 2'b01, 6'h20, 32'h0, 0, 32'h0, 0, 2, 32'h1020, 0, 0, 0));
    step();
    issue(I_JAL, 32'h100, mk(32'h100, 2'b00, 6'h03, 32'h104, 0, 32'h0, 0, 31, 32'h40, 0, 1, 0));
    step();
    issue(I_BEQ, 32'h104, mk(32'h104, 2'b00, 6'h04, 32'h1234, 5, 32'hCAFE, 7, 0, 32'hFFFF_FFFC, 1, 0, 0));
    step();
    issue(I_JR, 32'h108, mk(32'h108, 2'b01, 6'h08, 32'h1234, 5, 32'h0, 0, 0, 32'h8, 0, 0, 1));
    step();
    issue(I_FPU, 32'h10C, mk(32'h10C, 2'b10, 6'h01, 32'h1234, 5, 32'hCAFE, 7, 9, 32'h4801, 0, 0, 0));
    step();
    issue(I_SW, 32'h110, mk(32'h110, 2'b00, 6'h2B, 32'h1234, 5, 32'hCAFE, 7, 0, 32'h10, 0, 0, 0));
    step();

    // Stall: new instruction presented but the held ADD must stay put.
    issue(I_ADD3, 32'h200, mk(32'h200, 2'b01, 6'h20, 32'h1234, 5, 32'h1234, 5, 3, 32'h1820, 0, 0, 0));
    step();
    stall = 1'b1; in_instr = I_ORI; in_pc = 32'h204;
    #1 check_bit("in_ready_stall", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_de("stall_hold", mk(32'h200, 2'b01, 6'h20, 32'h1234, 5, 32'h1234, 5, 3, 32'h1820, 0, 0, 0));
    end
    stall = 1'b0;
    issue(I_ORI, 32'h204, mk(32'h204, 2'b00, 6'h0D, 32'hCAFE, 7, 32'h0, 8, 8, 32'h0000_8001, 0, 0, 0));
    step();

    issue(I_JAL, 32'h300, mk(32'h300, 2'b00, 6'h03, 32'h304, 0, 32'h0, 0, 31, 32'h40, 0, 1, 0));
    step();
    stall = 1'b1; flush = 1'b1; in_instr = I_BEQ; in_pc = 32'h304;
    #1 check_bit("in_ready_flush", in_ready, 1'b1);
    step();
    check_de("stall_flush", '0);
    stall = 1'b0; flush = 1'b0;

    issue(I_BEQ, 32'h304, mk(32'h304, 2'b00, 6'h04, 32'h1234, 5, 32'hCAFE, 7, 0, 32'hFFFF_FFFC, 1, 0, 0));
    step();
    stall = 1'b1; in_instr = I_JR; in_pc = 32'h308; rstn = 1'b0;
    step();
    check_de("reset_mid_stall", '0);
    rstn = 1'b1; stall = 1'b0; in_valid = 1'b0;
    #1 check_bit("in_ready_rereset", in_ready, 1'b1);

    // Registers were cleared by reset.
    issue(I_ADD3, 32'h10, mk(32'h10, 2'b01, 6'h20, 32'h0, 5, 32'h0, 5, 3, 32'h1820, 0, 0, 0));
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
